// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - circular instruction/PC buffer between fetch and execute with flush and drop counter
module inst_fetch_queue #(
  parameter int                 DATA_W   = 32,
  parameter int                 PC_W     = 30,
  parameter int                 DEPTH    = 4,
  parameter logic [DATA_W-1:0]  NOP_INST = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_inst,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_inst,
  output logic [PC_W-1:0]              out_pc,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  // Sum width wide enough that drop_cnt + count can never wrap before saturation.
  localparam int SW = ((CNT_W > CW) ? CNT_W : CW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] r_inst_mem [DEPTH];
  logic [PC_W-1:0]   r_pc_mem   [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [SW-1:0]     w_drop_sum;
  logic [CNT_W-1:0]  w_drop_next;
  logic [CW-1:0]     w_count_next;

  // Occupancy comes from the count register only; pointers are never compared.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // in_ready deliberately ignores out_ready: a full queue refuses a push even while it pops.
  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;

  assign w_push = in_valid & ~w_full;
  assign w_pop  = out_ready & ~w_empty;

  // Saturating accumulation of entries thrown away by a flush.
  assign w_drop_sum  = SW'(r_drop_cnt) + SW'(r_count);
  assign w_drop_next = (w_drop_sum > SW'(CNT_MAX)) ? CNT_MAX : w_drop_sum[CNT_W-1:0];

  // Next occupancy for a normal (no flush) cycle; simultaneous push/pop leaves it unchanged.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Storage write: contents are never cleared, only the outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (!reset && !flush && w_push) begin
      r_inst_mem[r_wr_ptr] <= in_inst;
      r_pc_mem[r_wr_ptr]   <= in_pc;
    end
  end

  // Pointer and occupancy state; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
    end
  end

  // Flush-drop counter; a flush on an empty queue adds zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (flush) begin
      r_drop_cnt <= w_drop_next;
    end
  end

  // Head read from storage only, so in_inst/in_pc have no path to the outputs.
  assign out_inst = w_empty ? NOP_INST   : r_inst_mem[r_rd_ptr];
  assign out_pc   = w_empty ? PC_W'(0)   : r_pc_mem[r_rd_ptr];
  assign count    = r_count;
  assign drop_cnt = r_drop_cnt;

endmodule
